// File: rtl/inv_mixcol_seq.sv
// Column-serial InvMixColumns engine: one 32-bit column per cycle through a single
// GF(2^8) multiplier column, with valid/ready on both sides and a per-block bypass.
module inv_mixcol_seq (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [0:127] value_i,
    input  logic         bypass_i,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [0:127] value_o,
    output logic         busy
);

    typedef enum logic [1:0] {IDLE, COL, DONE} state_t;

    state_t       state_q, state_d;
    logic [0:127] src_q, res_q;
    logic         byp_q;
    logic [1:0]   col_q;
    logic         accept;
    logic [0:31]  col_word, mix_word, res_col;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (8'h1b & {8{b[7]}});
    endfunction

    // 09/0b/0d/0e are assembled from the x2/x4/x8 doubling chain of each byte
    function automatic logic [0:31] inv_col(input logic [0:31] c);
        logic [7:0] x1 [4];
        logic [7:0] x2 [4];
        logic [7:0] x4 [4];
        logic [7:0] x8 [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        for (int k = 0; k < 4; k++) begin
            x1[k] = c[8*k +: 8];
            x2[k] = xtime(x1[k]);
            x4[k] = xtime(x2[k]);
            x8[k] = xtime(x4[k]);
            m9[k] = x8[k] ^ x1[k];
            mb[k] = x8[k] ^ x2[k] ^ x1[k];
            md[k] = x8[k] ^ x4[k] ^ x1[k];
            me[k] = x8[k] ^ x4[k] ^ x2[k];
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    always_comb begin
        col_word = src_q[{col_q, 5'd0} +: 32];
        mix_word = inv_col(col_word);
        res_col  = byp_q ? col_word : mix_word;
    end

    // in_ready in DONE follows out_ready combinationally so a new block can
    // be accepted on the same edge the finished one leaves
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = COL;
            end
            COL: begin
                busy = 1'b1;
                if (col_q == 2'd3) state_d = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) state_d = in_valid ? COL : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign accept  = in_valid & in_ready;
    assign value_o = res_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            src_q   <= '0;
            res_q   <= '0;
            byp_q   <= 1'b0;
            col_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                src_q <= value_i;
                byp_q <= bypass_i;
                col_q <= 2'd0;
            end
            // col_q wraps 3->0 on the last column, leaving it ready for the next block
            if (state_q == COL) begin
                res_q[{col_q, 5'd0} +: 32] <= res_col;
                col_q                      <= col_q + 2'd1;
            end
        end
    end

endmodule

// File: doc/inv_mixcol_seq.md
# inv_mixcol_seq

Column-serial InvMixColumns engine with a valid/ready handshake on both sides, for the inverse AES-128 round pipeline. It applies the {0e,0b,0d,09} GF(2^8) products to one 32-bit column per cycle. It sequences the four columns with a small FSM, so one multiplier column replaces sixteen parallel byte multipliers. A per-block bypass passes the state through unchanged at identical latency, which serves the final inverse round where InvMixColumns is skipped.

## Interface
Parameters: none.

- clk  input  1  rising-edge clock, single clock domain
- rst  input  1  reset, synchronous and active-high
- in_valid  input  1  value_i and bypass_i are valid
- in_ready  output  1  block can accept; transfer when in_valid & in_ready at a clk edge
- value_i  input  [0:127]  state in; byte k = value_i[8k:8k+7]; column c = bytes 4c..4c+3
- bypass_i  input  1  sampled with the input transfer; 1 = pass the state through unmodified
- out_valid  output  1  value_o holds a completed result
- out_ready  input  1  downstream accepts; transfer when out_valid & out_ready
- value_o  output  [0:127]  result state, same byte/column ordering as value_i
- busy  output  1  high in COL and DONE

## Operation
- FSM states:
  - IDLE: in_ready=1. On input transfer: capture value_i into src_q, bypass_i into byp_q, set col=0, go to COL.
  - COL: one column per cycle. Write result column col into res_q. Increment col (2-bit). When col==3, go to DONE.
  - DONE: out_valid=1. On output transfer: if in_valid also high, capture the new input and go to COL; otherwise go to IDLE.
- in_ready = (state==IDLE) | (state==DONE & out_ready). This is a combinational out_ready->in_ready path and is intentional.
- Column math for source bytes a0..a3 of column col, all in GF(2^8) with reduction polynomial 0x11b:
  - b0 = 0e·a0 ^ 0b·a1 ^ 0d·a2 ^ 09·a3
  - b1 = 09·a0 ^ 0e·a1 ^ 0b·a2 ^ 0d·a3
  - b2 = 0d·a0 ^ 09·a1 ^ 0e·a2 ^ 0b·a3
  - b3 = 0b·a0 ^ 0d·a1 ^ 09·a2 ^ 0e·a3
- Build the constants from xtime chains: 09=x8^x1, 0b=x8^x2^x1, 0d=x8^x4^x1, 0e=x8^x4^x2.
- byp_q=1: res_q column col = src_q column col, with identical cycle count.
- value_o = res_q. It changes during COL. Meaningful only while out_valid=1, and held stable while out_valid & !out_ready.
- in_valid while in_ready=0 is ignored; the source must hold it until transfer.

## Timing
- Reset (rst=1 at an edge): state=IDLE, col=0, out_valid=0, busy=0, value_o=0, src_q=0, byp_q=0. in_ready=1 from the following cycle.
- Reset mid-operation (COL or DONE): abort and discard the block. No out_valid pulse for it.
- Latency: input transfer at edge t. Columns 0..3 are written at edges t+1..t+4. out_valid is high from edge t+4 onward.
- Throughput: with out_ready held at 1 and in_valid continuously high, one block is accepted every 5 cycles, since DONE overlaps the next accept.
- Back-to-back: on the DONE edge where the output transfer and next input transfer coincide, out_valid drops and the new block starts column 0 on the next edge.
- Backpressure: out_ready=0 holds DONE indefinitely. out_valid, value_o and busy stay stable, and in_ready=0.
- col wraps 3->0 only when leaving COL. It never indexes beyond column 3.

## Test plan
- Single block, bypass_i=0, value_i=8e4da1bc_9fdc589d_01010101_c6c6c6c6 -> out_valid rises 4 cycles after the accept edge with value_o=db135345_f20a225c_01010101_c6c6c6c6.
- Same block with bypass_i=1 -> identical latency, value_o equals value_i exactly.
- Input 4d7ebdf8_d5d5d7d6_00000000_ffffffff -> 2d26314c_d4d4d4d5_00000000_ffffffff. Hold out_ready=0 for 10 cycles: value_o/out_valid stable and in_ready=0 throughout.
- Continuous stream of three blocks, alternating bypass, out_ready=1 -> accepts exactly 5 cycles apart, each output correct and in order, no lost or duplicated out_valid.
- Assert rst for 1 cycle during COL (col=2) -> next cycle out_valid=0, value_o=0, in_ready=1. A following block completes correctly.
- in_valid toggled while busy with a different value_i -> ignored. Output matches the first block only.
